// File: rtl/param_counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
`timescale 1ns/1ps
package param_counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Out-of-range load values become the top of the count range.
  function automatic logic [31:0] clamp_mod(input logic [31:0] value,
                                            input longint unsigned modulus);
    if (64'(value) >= modulus) return 32'(modulus - 64'd1);
    return value;
  endfunction

endpackage

// File: rtl/param_counter_if.sv
// Control inputs and count outputs of param_counter, bundled as one port.
`timescale 1ns/1ps
interface param_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             tc;

  modport master (output en, up, load, load_val, input count, tick, tc);
  modport slave  (input en, up, load, load_val, output count, tick, tc);
endinterface

// File: rtl/param_counter_prescaler.sv
// Divides enabled clock cycles by PRESCALE; tick marks the last phase.
`timescale 1ns/1ps
module param_counter_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  generate
    if (PRESCALE == 1) begin : g_bypass
      // No phase to track: every enabled cycle is a step.
      logic unused_ps;
      assign unused_ps = clk ^ rst_n ^ clr;
      assign tick      = en;
    end else begin : g_cnt
      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
      logic [PW-1:0] ps_q;

      assign tick = en & (ps_q == LAST);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   ps_q <= '0;
        else if (clr) ps_q <= '0;
        else if (en)  ps_q <= (ps_q == LAST) ? '0 : ps_q + PW'(1);
      end
    end
  endgenerate

endmodule

// File: rtl/param_counter.sv
// Count/tc datapath: load > step > hold, wrap or saturate at range ends.
`timescale 1ns/1ps
module param_counter
  import param_counter_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
  parameter int unsigned     PRESCALE = 1,
  parameter int              SATURATE = MODE_WRAP
) (
  input logic              clk,
  input logic              rst_n,
  param_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 64'd1);
  localparam bit               SAT  = (SATURATE == MODE_SAT);

  logic [WIDTH-1:0] cnt_q, cnt_nxt, ld_val;
  logic             tc_q, tc_nxt;
  logic             step;
  logic             at_max, at_zero;

  param_counter_prescaler #(.PRESCALE(PRESCALE)) u_ps (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .clr   (bus.load),
    .tick  (step)
  );

  assign ld_val  = WIDTH'(clamp_mod(32'(bus.load_val), MODULUS));
  assign at_max  = (cnt_q == MAXV);
  assign at_zero = (cnt_q == '0);

  always_comb begin
    cnt_nxt = cnt_q;
    tc_nxt  = 1'b0;
    if (bus.up) begin
      if (!at_max)   cnt_nxt = cnt_q + WIDTH'(1);
      else if (!SAT) cnt_nxt = '0;
      // Saturate pulses only on arrival at the end, wrap only on the wrap.
      tc_nxt = SAT ? (cnt_q == MAXV - WIDTH'(1)) : at_max;
    end else begin
      if (!at_zero)  cnt_nxt = cnt_q - WIDTH'(1);
      else if (!SAT) cnt_nxt = MAXV;
      tc_nxt = SAT ? (cnt_q == WIDTH'(1)) : at_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else if (bus.load) begin
      cnt_q <= ld_val;
      tc_q  <= 1'b0;
    end else if (step) begin
      cnt_q <= cnt_nxt;
      tc_q  <= tc_nxt;
    end else begin
      tc_q  <= 1'b0;
    end
  end

  assign bus.count = cnt_q;
  assign bus.tc    = tc_q;
  assign bus.tick  = step;

endmodule

// File: tb/tb_param_counter.sv
// Exercises five configurations of param_counter from one clock and reset.
`timescale 1ns/1ps
module tb_param_counter;
  import param_counter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  param_counter_if #(.WIDTH(4)) b0 ();
  param_counter_if #(.WIDTH(4)) b1 ();
  param_counter_if #(.WIDTH(4)) b2 ();
  param_counter_if #(.WIDTH(4)) b3 ();
  param_counter_if #(.WIDTH(5)) b4 ();

  param_counter #(.WIDTH(4)) d0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  param_counter #(.WIDTH(4), .MODULUS(10)) d1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  param_counter #(.WIDTH(4), .SATURATE(MODE_SAT)) d2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  param_counter #(.WIDTH(4), .PRESCALE(3)) d3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  param_counter #(.WIDTH(5), .MODULUS(16)) d4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  typedef struct {
    string       nm;
    int          d;
    logic [31:0] cnt;
    logic        tc;
  } exp_t;

  typedef struct {
    int          d;
    bit          en, up, load;
    logic [31:0] lv;
    logic [31:0] ec;
    bit          et;
    bit          ck;
    bit          etk;
    string       nm;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int d, input bit e, input bit u, input bit l, input logic [31:0] lv);
    case (d)
      0: begin b0.en = e; b0.up = u; b0.load = l; b0.load_val = lv[3:0]; end
      1: begin b1.en = e; b1.up = u; b1.load = l; b1.load_val = lv[3:0]; end
      2: begin b2.en = e; b2.up = u; b2.load = l; b2.load_val = lv[3:0]; end
      3: begin b3.en = e; b3.up = u; b3.load = l; b3.load_val = lv[3:0]; end
      default: begin b4.en = e; b4.up = u; b4.load = l; b4.load_val = lv[4:0]; end
    endcase
  endtask

  function automatic logic [31:0] rd_cnt(input int d);
    case (d)
      0: return 32'(b0.count);
      1: return 32'(b1.count);
      2: return 32'(b2.count);
      3: return 32'(b3.count);
      default: return 32'(b4.count);
    endcase
  endfunction

  function automatic logic rd_tc(input int d);
    case (d)
      0: return b0.tc;
      1: return b1.tc;
      2: return b2.tc;
      3: return b3.tc;
      default: return b4.tc;
    endcase
  endfunction

  function automatic logic rd_tick(input int d);
    case (d)
      0: return b0.tick;
      1: return b1.tick;
      2: return b2.tick;
      3: return b3.tick;
      default: return b4.tick;
    endcase
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input int d, input bit e, input bit u, input bit l, input logic [31:0] lv,
                       input logic [31:0] ec, input bit et, input bit ck, input bit etk,
                       input string nm);
    exp_t x;
    @(negedge clk);
    drive(d, e, u, l, lv);
    sbq.push_back('{nm, d, ec, et});
    if (ck) begin
      #1;
      chk({nm, " tick"}, 32'(rd_tick(d)), 32'(etk));
    end
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk({nm, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      x = sbq.pop_front();
      chk({x.nm, " count"}, rd_cnt(x.d), x.cnt);
      chk({x.nm, " tc"}, 32'(rd_tc(x.d)), 32'(x.tc));
    end
  endtask

  task automatic run_vt();
    foreach (vt[i])
      apply(vt[i].d, vt[i].en, vt[i].up, vt[i].load, vt[i].lv,
            vt[i].ec, vt[i].et, vt[i].ck, vt[i].etk, vt[i].nm);
    vt.delete();
  endtask

  task automatic add(input int d, input bit e, input bit u, input bit l, input logic [31:0] lv,
                     input logic [31:0] ec, input bit et, input bit ck, input bit etk,
                     input string nm);
    vt.push_back('{d, e, u, l, lv, ec, et, ck, etk, nm});
  endtask

  task automatic do_reset();
    for (int d = 0; d < 5; d++) drive(d, 1'b0, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

  initial begin
    do_reset();
    #1;
    for (int d = 0; d < 5; d++) begin
      chk($sformatf("reset d%0d count", d), rd_cnt(d), 32'd0);
      chk($sformatf("reset d%0d tc", d), 32'(rd_tc(d)), 32'd0);
    end

    // Original LED test: free-running 4-bit up count.
    for (int i = 1; i <= 63; i++)
      apply(0, 1, 1, 0, 0, 32'(i % 16), (i % 16) == 0, 0, 0, $sformatf("led edge %0d", i));
    apply(0, 1, 1, 0, 0, 0, 1, 0, 0, "led wrap 64");
    apply(0, 0, 1, 0, 0, 0, 0, 0, 0, "en low forces tc 0");
    for (int i = 1; i <= 11; i++)
      apply(0, 1, 1, 0, 0, 32'(i), 0, 0, 0, $sformatf("led to 11 %0d", i));
    // Async reset mid-cycle, checked before the next clock edge.
    drive(0, 0, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset count", rd_cnt(0), 32'd0);
    chk("async reset tc", 32'(rd_tc(0)), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Modulus 10 down count from reset.
    for (int i = 1; i <= 12; i++)
      add(1, 1, 0, 0, 0, 32'((10 - (i % 10)) % 10), (i == 1) || (i == 11), 0, 0,
          $sformatf("mod10 down %0d", i));
    run_vt();

    // Saturate: hold at both ends with a single arrival pulse.
    add(2, 1, 1, 1, 13, 13, 0, 0, 0, "sat load 13");
    add(2, 1, 1, 0, 0, 14, 0, 0, 0, "sat up 14");
    add(2, 1, 1, 0, 0, 15, 1, 0, 0, "sat arrive 15");
    add(2, 1, 1, 0, 0, 15, 0, 0, 0, "sat hold 15 a");
    add(2, 1, 1, 0, 0, 15, 0, 0, 0, "sat hold 15 b");
    add(2, 1, 1, 0, 0, 15, 0, 0, 0, "sat hold 15 c");
    add(2, 1, 0, 1, 1, 1, 0, 0, 0, "sat load 1");
    add(2, 1, 0, 0, 0, 0, 1, 0, 0, "sat arrive 0");
    add(2, 1, 0, 0, 0, 0, 0, 0, 0, "sat hold 0");
    run_vt();

    // Prescale 3: phase, load clears phase, enable pause, direction change.
    do_reset();
    add(3, 1, 1, 0, 0, 0, 0, 1, 0, "ps e1");
    add(3, 1, 1, 0, 0, 0, 0, 1, 0, "ps e2");
    add(3, 1, 1, 0, 0, 1, 0, 1, 1, "ps e3");
    add(3, 1, 1, 0, 0, 1, 0, 1, 0, "ps e4");
    add(3, 1, 1, 0, 0, 1, 0, 1, 0, "ps e5");
    add(3, 1, 1, 0, 0, 2, 0, 1, 1, "ps e6");
    add(3, 1, 1, 0, 0, 2, 0, 1, 0, "ps e7");
    add(3, 1, 1, 1, 7, 7, 0, 1, 0, "ps load 7");
    add(3, 1, 1, 0, 0, 7, 0, 1, 0, "ps e9");
    add(3, 1, 1, 0, 0, 7, 0, 1, 0, "ps e10");
    add(3, 1, 1, 0, 0, 8, 0, 1, 1, "ps e11");
    add(3, 1, 1, 0, 0, 8, 0, 1, 0, "ps e12");
    for (int i = 0; i < 5; i++)
      add(3, 0, 1, 0, 0, 8, 0, 1, 0, $sformatf("ps pause %0d", i));
    add(3, 1, 1, 0, 0, 8, 0, 1, 0, "ps resume");
    add(3, 1, 1, 0, 0, 9, 0, 1, 1, "ps resume step");
    add(3, 1, 0, 0, 0, 9, 0, 1, 0, "ps down a");
    add(3, 1, 0, 0, 0, 9, 0, 1, 0, "ps down b");
    add(3, 1, 0, 0, 0, 8, 0, 1, 1, "ps down step");
    run_vt();

    // Width 5, modulus 16: load clamp and wrap below the register range.
    add(4, 1, 1, 1, 20, 15, 0, 0, 0, "w5 load 20");
    add(4, 1, 1, 0, 0, 0, 1, 0, 0, "w5 wrap");
    add(4, 1, 1, 1, 9, 9, 0, 0, 0, "w5 load 9");
    add(4, 0, 1, 1, 16, 15, 0, 0, 0, "w5 load 16");
    add(4, 0, 1, 1, 31, 15, 0, 0, 0, "w5 load 31");
    add(4, 1, 0, 1, 0, 0, 0, 0, 0, "w5 load 0");
    add(4, 1, 0, 0, 0, 15, 1, 0, 0, "w5 down wrap");
    run_vt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
